// File: rtl/tlc_conflict_monitor.sv
// Safety monitor for the T-intersection light buses: arms on stable valid input,
// then checks encoding, conflicts, sequencing, yellow time and (TLM_WATCHDOG_EN) a watchdog.
module tlc_conflict_monitor #(
  parameter int ARM_CYCLES = 2,
  parameter int MIN_YELLOW = 3,
  parameter int MAX_STABLE = 16,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light_M1,
  input  logic [2:0] light_M2,
  input  logic [2:0] light_MT,
  input  logic [2:0] light_S,
  input  logic       fault_clr,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [3:0] fault_light,
  output logic       flash
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int AW = $clog2(ARM_CYCLES) + 1;
  localparam int YW = $clog2(MIN_YELLOW) + 1;
  localparam int SW = $clog2(MAX_STABLE) + 1;
  localparam int FW = $clog2(FLASH_HALF) + 1;

  localparam logic [AW-1:0] ARM_LAST   = AW'(ARM_CYCLES - 1);
  localparam logic [YW-1:0] YEL_LIMIT  = YW'(MIN_YELLOW);
  localparam logic [SW-1:0] WD_LIMIT   = SW'(MAX_STABLE);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  typedef enum logic [1:0] {ST_ARM, ST_MONITOR, ST_FAULT} state_e;

  function automatic logic is_valid(input logic [2:0] l);
    return (l == RED) || (l == YEL) || (l == GRN);
  endfunction

  function automatic logic is_nonred(input logic [2:0] l);
    return (l == YEL) || (l == GRN);
  endfunction

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == RED && c == GRN) || (p == GRN && c == YEL) ||
           (p == YEL && c == RED);
  endfunction

  // Index 0..3 = M1, M2, MT, S, matching the fault_light bit order.
  logic [3:0][2:0] cur;
  assign cur = {light_S, light_MT, light_M2, light_M1};

  state_e                 state_q, state_d;
  logic [AW-1:0]          arm_cnt_q, arm_cnt_d;
  logic [3:0][2:0]        prev_q, prev_d;
  logic [3:0][YW-1:0]     ycnt_q, ycnt_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   flash_q, flash_d;
  logic                   fault_q, fault_d;
  logic [2:0]             code_q, code_d;
  logic [3:0]             flt_light_q, flt_light_d;

  logic [3:0] bad_enc, nonred, bad_seq, short_y;
  logic       wd_hit;
  logic [2:0] viol_code;
  logic [3:0] viol_mask;

`ifdef TLM_WATCHDOG_EN
  logic [SW-1:0] stable_q, stable_d, stable_inc;
  assign stable_inc = (stable_q == WD_LIMIT) ? stable_q : stable_q + SW'(1);
  assign wd_hit     = (cur == prev_q) && (stable_inc == WD_LIMIT);
`else
  logic unused_wd;
  assign unused_wd = ^WD_LIMIT;
  assign wd_hit    = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bad_enc[i] = !is_valid(cur[i]);
      nonred[i]  = is_nonred(cur[i]);
      bad_seq[i] = !legal_step(prev_q[i], cur[i]);
      short_y[i] = (prev_q[i] == YEL) && (cur[i] == RED) && (ycnt_q[i] < YEL_LIMIT);
    end
  end

  // Lowest code wins; the mask belongs to the winning code only.
  always_comb begin
    viol_code = 3'd0;
    viol_mask = 4'b0000;
    if (|bad_enc) begin
      viol_code = 3'd1;
      viol_mask = bad_enc;
    end else if (nonred[3] && |nonred[2:0]) begin
      viol_code = 3'd2;
      viol_mask = {1'b1, nonred[2:0]};
    end else if (nonred[2] && nonred[1]) begin
      viol_code = 3'd3;
      viol_mask = 4'b0110;
    end else if (|bad_seq) begin
      viol_code = 3'd4;
      viol_mask = bad_seq;
    end else if (|short_y) begin
      viol_code = 3'd5;
      viol_mask = short_y;
    end else if (wd_hit) begin
      viol_code = 3'd6;
      viol_mask = 4'b0000;
    end
  end

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    prev_d      = prev_q;
    ycnt_d      = ycnt_q;
    fcnt_d      = fcnt_q;
    flash_d     = flash_q;
    fault_d     = fault_q;
    code_d      = code_q;
    flt_light_d = flt_light_q;
`ifdef TLM_WATCHDOG_EN
    stable_d    = stable_q;
`endif
    case (state_q)
      ST_ARM: begin
        if (|bad_enc) begin
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d   = ST_MONITOR;
          arm_cnt_d = '0;
          prev_d    = cur;
          ycnt_d    = '0;
`ifdef TLM_WATCHDOG_EN
          stable_d  = '0;
`endif
        end else begin
          arm_cnt_d = arm_cnt_q + AW'(1);
        end
      end
      ST_MONITOR: begin
        if (viol_code != 3'd0) begin
          state_d     = ST_FAULT;
          fault_d     = 1'b1;
          code_d      = viol_code;
          flt_light_d = viol_mask;
          flash_d     = 1'b1;
          fcnt_d      = '0;
        end else begin
          prev_d = cur;
          for (int i = 0; i < 4; i++) begin
            if (cur[i] == YEL)
              ycnt_d[i] = (ycnt_q[i] == YEL_LIMIT) ? ycnt_q[i] : ycnt_q[i] + YW'(1);
            else
              ycnt_d[i] = '0;
          end
`ifdef TLM_WATCHDOG_EN
          stable_d = (cur == prev_q) ? stable_inc : '0;
`endif
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d     = ST_ARM;
          arm_cnt_d   = '0;
          prev_d      = {4{RED}};
          ycnt_d      = '0;
          fcnt_d      = '0;
          flash_d     = 1'b0;
          fault_d     = 1'b0;
          code_d      = 3'd0;
          flt_light_d = 4'b0000;
`ifdef TLM_WATCHDOG_EN
          stable_d    = '0;
`endif
        end else if (fcnt_q == FLASH_LAST) begin
          fcnt_d  = '0;
          flash_d = !flash_q;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: state_d = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ARM;
      arm_cnt_q   <= '0;
      prev_q      <= {4{RED}};
      ycnt_q      <= '0;
      fcnt_q      <= '0;
      flash_q     <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= 3'd0;
      flt_light_q <= 4'b0000;
`ifdef TLM_WATCHDOG_EN
      stable_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      prev_q      <= prev_d;
      ycnt_q      <= ycnt_d;
      fcnt_q      <= fcnt_d;
      flash_q     <= flash_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      flt_light_q <= flt_light_d;
`ifdef TLM_WATCHDOG_EN
      stable_q    <= stable_d;
`endif
    end
  end

  assign armed       = (state_q == ST_MONITOR);
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign fault_light = flt_light_q;
  assign flash       = flash_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed bench for tlc_conflict_monitor; inputs change and outputs are sampled 1ns after posedge.
module tb_tlc_conflict_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] light_M1 = 3'b100, light_M2 = 3'b100, light_MT = 3'b100, light_S = 3'b100;
  logic       fault_clr = 1'b0;
  logic       armed, fault, flash;
  logic [2:0] fault_code;
  logic [3:0] fault_light;

  int n_checks = 0;
  int n_pass   = 0;

  tlc_conflict_monitor dut (
    .clk(clk), .rst(rst),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .fault_clr(fault_clr),
    .armed(armed), .fault(fault), .fault_code(fault_code),
    .fault_light(fault_light), .flash(flash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pattern order {M1, M2, MT, S}.
  task automatic set_l(input logic [11:0] p);
    {light_M1, light_M2, light_MT, light_S} = p;
  endtask

  task automatic reset_arm(input string tag, input logic [11:0] p);
    set_l(p);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check({tag, "_armed_early"}, 16'(armed), 16'd0);
    tick();
    check({tag, "_armed"}, 16'(armed), 16'd1);
  endtask

  task automatic check_fault(input string tag, input logic [2:0] code, input logic [3:0] mask);
    check({tag, "_fault"}, 16'(fault), 16'd1);
    check({tag, "_code"},  16'(fault_code), 16'(code));
    check({tag, "_light"}, 16'(fault_light), 16'(mask));
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_armed"}, 16'(armed), 16'd0);
    check({tag, "_fault"}, 16'(fault), 16'd0);
    check({tag, "_code"},  16'(fault_code), 16'd0);
    check({tag, "_light"}, 16'(fault_light), 16'd0);
    check({tag, "_flash"}, 16'(flash), 16'd0);
  endtask

  localparam logic [11:0] P_S1 = 12'b001_001_100_100;
  localparam logic [11:0] P_S2 = 12'b001_010_100_100;
  localparam logic [11:0] P_S3 = 12'b001_100_001_100;
  localparam logic [11:0] P_S4 = 12'b010_100_010_100;
  localparam logic [11:0] P_S5 = 12'b100_100_100_001;
  localparam logic [11:0] P_S6 = 12'b100_100_100_010;

  function automatic logic [11:0] legal_pat(input int t);
    if (t < 8)       return P_S1;
    else if (t < 11) return P_S2;
    else if (t < 17) return P_S3;
    else if (t < 20) return P_S4;
    else if (t < 24) return P_S5;
    else             return P_S6;
  endfunction

  initial begin
    logic [11:0] flash_seen;
    int          faults_seen;

    // Reset values while rst is held
    #1;
    check_clear("reset");

    // Legal cycle for 200+ cycles: arms on the second sample and never faults
    set_l(P_S1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    faults_seen = 0;
    for (int c = 0; c < 202; c++) begin
      set_l(legal_pat(c % 27));
      tick();
      if (c == 1) check("legal_armed", 16'(armed), 16'd1);
      if (fault) faults_seen++;
    end
    check("legal_no_fault", 16'(faults_seen), 16'd0);
    check("legal_still_armed", 16'(armed), 16'd1);

    // Side conflict, flash pattern, outputs hold, clear wins over live violation
    reset_arm("side", 12'b001_100_100_100);
    set_l(12'b001_100_100_001);
    tick();
    check_fault("side", 3'd2, 4'b1001);
    check("side_armed_in_fault", 16'(armed), 16'd0);
    for (int i = 0; i < 12; i++) begin
      flash_seen[11-i] = flash;
      if (i < 11) tick();
    end
    check("side_flash_pattern", 16'(flash_seen), 16'b1111_0000_1111);
    check("side_code_hold", 16'(fault_code), 16'd2);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check_clear("clr");
    set_l(12'b001_100_100_100);
    tick();
    check("rearm_early", 16'(armed), 16'd0);
    tick();
    check("rearm", 16'(armed), 16'd1);

    // Short yellow (2 cycles) faults; exactly MIN_YELLOW does not
    reset_arm("sy", P_S1);
    set_l(P_S2);
    tick(2);
    set_l(12'b001_100_100_100);
    tick();
    check_fault("short_yellow", 3'd5, 4'b0010);
    reset_arm("y3", P_S1);
    set_l(P_S2);
    tick(3);
    set_l(12'b001_100_100_100);
    tick();
    check("yellow3_no_fault", 16'(fault), 16'd0);
    check("yellow3_armed", 16'(armed), 16'd1);

    // Encoding beats sequence on the same sample
    reset_arm("enc", P_S1);
    set_l(12'b100_001_100_011);
    tick();
    check_fault("enc_priority", 3'd1, 4'b1000);

    // fault_clr ignored in MONITOR; green->red alone is a sequence fault
    reset_arm("seq", P_S1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("clr_ignored_monitor", 16'(armed), 16'd1);
    set_l(12'b100_001_100_100);
    tick();
    check_fault("seq", 3'd4, 4'b0001);

    // Turn conflict, then async reset mid-FAULT without a clock edge
    reset_arm("turn", 12'b100_001_100_100);
    set_l(12'b100_001_001_100);
    tick();
    check_fault("turn", 3'd3, 4'b0110);
    rst = 1'b1;
    #1;
    check_clear("async_rst");
    rst = 1'b0;

    // Watchdog on a static legal pattern
    reset_arm("wd", P_S1);
`ifdef TLM_WATCHDOG_EN
    tick(15);
    check("wd_before_limit", 16'(fault), 16'd0);
    tick();
    check_fault("wd", 3'd6, 4'b0000);
`else
    tick(100);
    check("static_no_fault", 16'(fault), 16'd0);
    check("static_armed", 16'(armed), 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tlc_conflict_monitor.md
Name: tlc_conflict_monitor

Overview:
- Independent safety monitor on the receiving end of the T-intersection light buses (light_M1, light_M2, light_MT, light_S).
- Samples all four lights every clock and checks:
  - encoding
  - conflicting greens
  - colour sequencing
  - minimum yellow time
  - phase watchdog
- On the first violation it latches a fault, reports the cause and drives a flash strobe for a red-flash override stage.

Parameters:
- ARM_CYCLES, 2: consecutive all-valid samples required before monitoring starts.
- MIN_YELLOW, 3: minimum consecutive yellow samples before yellow->red.
- MAX_STABLE, 16: cycles with no change on any light before watchdog fault.
- FLASH_HALF, 4: flash half-period in cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- light_M1  input  3  main dominant light; 100 red, 010 yellow, 001 green
- light_M2  input  3  main opposite light, same encoding
- light_MT  input  3  main left-turn light, same encoding
- light_S  input  3  side-road light, same encoding
- fault_clr  input  1  synchronous clear of latched fault
- armed  output  1  monitor in MONITOR state
- fault  output  1  latched fault
- fault_code  output  3  cause of latched fault, 0 = none
- fault_light  output  4  lights involved; bit0 M1, bit1 M2, bit2 MT, bit3 S
- flash  output  1  red-flash strobe, active only in FAULT

Behaviour:
- Reset (async, any time, including mid-FAULT): state ARM, armed=0, fault=0, fault_code=0, fault_light=0, flash=0, all counters 0, prev-light registers 100.
- Valid encoding is one of 100, 010, 001. Non-red means 010 or 001.
- ARM state:
  - Counts consecutive samples in which all four lights are valid; any invalid sample clears the count.
  - When the count reaches ARM_CYCLES: go to MONITOR, load prev registers from the current sample, zero the stable and yellow counters.
  - No checks run in ARM.
- MONITOR state: all checks run on each sample against prev. Any violation moves to FAULT on the same edge, so fault/code/light are visible after the sampling edge.
- Check codes:
  - 1 illegal encoding: any light not valid. Mask = offending lights.
  - 2 side conflict: S non-red while any of M1/M2/MT is non-red. Mask = S plus the non-red mains.
  - 3 turn conflict: MT non-red while M2 non-red. Mask = 0110.
  - 4 illegal sequence: per light, prev->cur must be a hold, red->green, green->yellow or yellow->red. Anything else (green->red, red->yellow, yellow->green) faults. Mask = offending lights.
  - 5 short yellow: per light, a yellow counter increments while yellow (saturates at MIN_YELLOW) and resets otherwise. A yellow->red transition with counter < MIN_YELLOW faults. Mask = offending lights.
  - 6 watchdog: counter of cycles since any light changed. When it reaches MAX_STABLE, fault. Mask = 0000.
- Simultaneous violations: lowest code wins; mask reflects only that code.
- FAULT state:
  - Outputs hold; new violations are ignored.
  - flash=1 on entry and toggles every FLASH_HALF cycles.
  - Exit only on fault_clr=1 (-> ARM, all outputs to reset values) or on rst.
- fault_clr is ignored in ARM and MONITOR.
- If fault_clr and a violation coincide while in FAULT, clear wins.
- Counters are sized by $clog2 of their parameter plus 1; no wrap is allowed (saturate).

Optional Feature:
- Macro TLM_WATCHDOG_EN.
- Defined: code 6 watchdog check and its counter are present.
- Undefined: no watchdog counter exists, code 6 is never produced, and a static light pattern never faults.

Test Plan:
- Drive the legal cycle repeatedly: S1 M1/M2 green 8 cycles; S2 M2 yellow 3; S3 M1/MT green 6; S4 M1/MT yellow 3; S5 S green 4; S6 S yellow 3. -> armed=1 after 2 cycles; fault stays 0 for 200 cycles.
- After arming, set S=001 while M1=001. -> fault=1, fault_code=2, fault_light=1001 after that edge; flash pattern 1111 0000 1111.
- After arming, M2 goes 001->010 for 2 cycles then ->100. -> fault_code=5, fault_light=0010. Repeat with 3 yellow cycles -> no fault.
- After arming, M1 goes 001->100 directly while S=010 illegal-encoded as 011 on the same sample. -> fault_code=1 (priority over 4), fault_light=1000.
- With TLM_WATCHDOG_EN defined, hold a legal pattern for 16 cycles. -> fault_code=6, fault_light=0000. Undefined -> no fault after 100 cycles.
- In FAULT, pulse fault_clr. -> next edge armed=0, fault=0, code=0, flash=0; re-arms after 2 valid samples. Assert rst mid-FAULT -> outputs zero immediately, without a clock edge.
